wave_i2s_tx: RTL and testbench
==============================

// Module: wave_i2s_tx
// PURPOSE
//  Downstream output stage for the filter: serialises the 24-bit filtered WaveOut sample onto a
//  Philips-I2S link (Bclk/Lrclk/Sdata) for an external audio DAC. A new sample is latched once per
//  frame, at the left-slot boundary. Mono by default: the same sample is sent in both slots.
// PARAMETERS
//  CLK_DIV    8   Clock cycles per Bclk half-period (Bclk = Clock/(2*CLK_DIV)); legal range >=1
//  WORD_BITS  24  sample width; MSB-first, left-aligned in each slot, LSB padding is 0
//  FRAME_BITS 32  Bclk periods per channel slot; must be >= WORD_BITS; frame = 2*FRAME_BITS bits
// PORTS
//  Clock        in   1          system clock; all logic on posedge
//  Reset        in   1          async, active-high; clears all state
//  WaveIn       in   WORD_BITS  two's-complement sample (filter WaveOut); sampled only at latch
//  Enable       in   1          run request; sampled each Clock
//  Bclk         out  1          I2S bit clock
//  Lrclk        out  1          word select: 0 = left slot, 1 = right slot
//  Sdata        out  1          serial data; changes only on Bclk falling edge
//  SampleTaken  out  1          1-cycle pulse on the Clock edge that latches WaveIn
//  Busy         out  1          1 while in RUN
// BEHAVIOUR
//  Reset: state=IDLE; Bclk=Lrclk=Sdata=SampleTaken=Busy=0; divCnt=bitIdx=0; shift reg=0.
//  Assertion mid-frame aborts immediately. No partial-frame resume after release.
//  States: IDLE, RUN.
//  IDLE, Enable=1 -> next edge: RUN, bitIdx=0, divCnt=0, latch WaveIn, SampleTaken=1,
//    Sdata=WaveIn[WORD_BITS-1], Lrclk=0, Bclk=0, Busy=1. Latency Enable->first Sdata = 1 cycle.
//  RUN: divCnt counts 0..CLK_DIV-1. On the cycle divCnt==CLK_DIV-1: toggle Bclk, divCnt<=0.
//  Bclk 0->1 edge: no data change. DAC samples here.
//  Bclk 1->0 edge: bitIdx <= (bitIdx+1) mod 2*FRAME_BITS; Sdata/Lrclk update on that same edge.
//  Bit slot b (0..2F-1, F=FRAME_BITS):
//    channel = b/F; pos = b mod F;
//    Sdata = pos<WORD_BITS ? word[WORD_BITS-1-pos] : 0.
//  Lrclk at slot b = (((b+1) mod 2F) >= F). Word select leads the MSB by one Bclk, per I2S.
//  Latch: when bitIdx wraps 2F-1 -> 0, capture WaveIn into sample reg.
//    Sdata takes the new MSB in that cycle. SampleTaken pulses for exactly 1 Clock.
//    Exactly one latch per 2F Bclk periods, including the first.
//  Right slot (mono) transmits the same latched word as the left slot. WaveIn changes mid-frame
//    are ignored.
//  Enable deassert in RUN: the current frame completes. At the wrap where the next latch would
//    occur, go to IDLE instead: Bclk=Lrclk=Sdata=0, Busy=0, no SampleTaken.
//  Enable re-asserted before that wrap: RUN continues seamlessly.
//  No arithmetic on data: bits pass unmodified; no saturation or rounding.
// CONFIGURATION
//  I2S_STEREO_EN defined: adds input port WaveInR [WORD_BITS-1:0].
//    At the frame latch, WaveIn feeds the left slot and WaveInR the right slot, both captured
//    on the same edge.
//  I2S_STEREO_EN undefined: no WaveInR port; the right slot repeats the left word.
// TESTING  (CLK_DIV=2, WORD_BITS=24, FRAME_BITS=32 unless noted)
//  1 Reset held, Enable=1 -> all outputs 0. Release; Enable=1 -> SampleTaken=1 next cycle,
//    Sdata=MSB, Busy=1.
//  2 WaveIn=24'hA5C3F1 -> Bclk period 4 Clocks; bits 0..23 on Bclk rises = A5C3F1 MSB-first;
//    bits 24..31=0; right slot repeats A5C3F1.
//  3 Lrclk check -> Lrclk rises on fall ending slot b=30, falls on fall ending b=62; SampleTaken
//    every 256 Clocks.
//  4 WaveIn changed to 24'h123456 mid-left-slot -> current frame still sends A5C3F1;
//    next frame sends 123456.
//  5 Enable=0 at bit 10 -> frame runs to bit 63, then IDLE with Bclk=0 and Busy=0.
//    Enable=0 then 1 within the frame -> no gap.
//  6 Reset pulse at bit 40 -> outputs 0 asynchronously. After release with Enable=1 -> fresh
//    frame from bitIdx 0. With I2S_STEREO_EN and WaveInR=24'h800001, the right slot carries
//    800001.

Source files
------------

// File: rtl/wave_i2s_tx_if.sv
// wave_i2s_tx_if: sample/control/I2S bundle for the wave_i2s_tx output stage.
//   master : sample source side (drives WaveIn, Enable; observes link + status)
//   slave  : the serialiser (wave_i2s_tx)
//   WaveIn[R]   sample(s) to send, captured once per frame
//   Enable      run request
//   Bclk/Lrclk/Sdata  Philips-I2S link to the DAC
//   SampleTaken one-cycle pulse on the capture edge; Busy high while running
// Optional: I2S_STEREO_EN adds WaveInR (right-slot sample).
interface wave_i2s_tx_if #(
  parameter int WORD_BITS = 24
);
  logic [WORD_BITS-1:0] WaveIn;
`ifdef I2S_STEREO_EN
  logic [WORD_BITS-1:0] WaveInR;
`endif
  logic Enable;
  logic Bclk;
  logic Lrclk;
  logic Sdata;
  logic SampleTaken;
  logic Busy;

  modport master (
`ifdef I2S_STEREO_EN
    output WaveInR,
`endif
    output WaveIn, Enable,
    input  Bclk, Lrclk, Sdata, SampleTaken, Busy
  );

  modport slave (
`ifdef I2S_STEREO_EN
    input  WaveInR,
`endif
    input  WaveIn, Enable,
    output Bclk, Lrclk, Sdata, SampleTaken, Busy
  );
endinterface

// File: rtl/wave_i2s_tx.sv
// wave_i2s_tx: serialises the filtered 24-bit sample onto a Philips-I2S link.
// One sample is captured per frame at the left-slot boundary; mono by default
// (right slot repeats the left word). All outputs are registered.
//   Clock  system clock (posedge)
//   Reset  async active-high, clears everything
//   bus    wave_i2s_tx_if.slave: WaveIn[, WaveInR], Enable in;
//          Bclk, Lrclk, Sdata, SampleTaken, Busy out
// Optional: define I2S_STEREO_EN to send WaveInR in the right slot.
module wave_i2s_tx #(
  parameter int CLK_DIV    = 8,
  parameter int WORD_BITS  = 24,
  parameter int FRAME_BITS = 32
) (
  input  logic Clock,
  input  logic Reset,
  wave_i2s_tx_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] SLOT_F    = BIT_W'(FRAME_BITS);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(2 * FRAME_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Data bit for slot b of word w. Positions past WORD_BITS shift every bit
  // out of the word, which yields the zero LSB padding for free.
  function automatic logic slot_bit(input logic [WORD_BITS-1:0] w,
                                    input logic [BIT_W-1:0] b);
    logic [BIT_W-1:0]     pos;
    logic [WORD_BITS-1:0] sh;
    pos = (b >= SLOT_F) ? b - SLOT_F : b;
    sh  = w << pos;
    return sh[WORD_BITS-1];
  endfunction

  // Word select leads the data by one bit: it reflects the slot after b.
  function automatic logic slot_lr(input logic [BIT_W-1:0] b);
    logic [BIT_W-1:0] nxt;
    nxt = (b == SLOT_LAST) ? '0 : b + BIT_W'(1);
    return nxt >= SLOT_F;
  endfunction

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_BITS-1:0] samp_q, samp_d;
`ifdef I2S_STEREO_EN
  logic [WORD_BITS-1:0] sampr_q, sampr_d;
`endif
  logic bclk_q, bclk_d;
  logic lrclk_q, lrclk_d;
  logic sdata_q, sdata_d;
  logic taken_q, taken_d;
  logic busy_q, busy_d;

  logic [BIT_W-1:0]     nb;
  logic [WORD_BITS-1:0] wsel;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
`ifdef I2S_STEREO_EN
    sampr_d = sampr_q;
`endif
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    taken_d = 1'b0;
    busy_d  = busy_q;
    nb      = (bit_q == SLOT_LAST) ? '0 : bit_q + BIT_W'(1);
`ifdef I2S_STEREO_EN
    wsel    = (nb >= SLOT_F) ? sampr_q : samp_q;
`else
    wsel    = samp_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.Enable) begin
          state_d = RUN;
          div_d   = '0;
          bit_d   = '0;
          samp_d  = bus.WaveIn;
`ifdef I2S_STEREO_EN
          sampr_d = bus.WaveInR;
`endif
          taken_d = 1'b1;
          sdata_d = bus.WaveIn[WORD_BITS-1];
          lrclk_d = slot_lr('0);
          bclk_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          // Data and word select only move on the Bclk falling edge.
          if (bclk_q) begin
            bit_d = nb;
            if (bit_q == SLOT_LAST) begin
              if (bus.Enable) begin
                samp_d  = bus.WaveIn;
`ifdef I2S_STEREO_EN
                sampr_d = bus.WaveInR;
`endif
                taken_d = 1'b1;
                sdata_d = bus.WaveIn[WORD_BITS-1];
                lrclk_d = slot_lr('0);
              end else begin
                // Frame boundary with no run request: park the link low.
                state_d = IDLE;
                sdata_d = 1'b0;
                lrclk_d = 1'b0;
                busy_d  = 1'b0;
              end
            end else begin
              sdata_d = slot_bit(wsel, nb);
              lrclk_d = slot_lr(nb);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
`ifdef I2S_STEREO_EN
      sampr_q <= '0;
`endif
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      taken_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
`ifdef I2S_STEREO_EN
      sampr_q <= sampr_d;
`endif
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      taken_q <= taken_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Bclk        = bclk_q;
  assign bus.Lrclk       = lrclk_q;
  assign bus.Sdata       = sdata_q;
  assign bus.SampleTaken = taken_q;
  assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_wave_i2s_tx.sv
// tb_wave_i2s_tx: directed bench for wave_i2s_tx (CLK_DIV=2, 24-bit word,
// 32-bit slots). Frames are captured bit-by-bit on Bclk rising edges and
// compared with hand-built expected frames.
module tb_wave_i2s_tx;
  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;
`ifdef I2S_STEREO_EN
  localparam logic [23:0] RIGHT_FINAL = 24'h800001;
`else
  localparam logic [23:0] RIGHT_FINAL = 24'hA5C3F1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  wave_i2s_tx_if #(.WORD_BITS(24)) bus ();

  wave_i2s_tx #(.CLK_DIV(2), .WORD_BITS(24), .FRAME_BITS(32)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_word(input logic [23:0] l, input logic [23:0] r);
    bus.WaveIn = l;
`ifdef I2S_STEREO_EN
    bus.WaveInR = r;
`else
    if (r != l) $display("note: right word %h ignored in mono build", r);
`endif
  endtask

  // Runs one full frame (256 clocks) starting from a capture cycle.
  task automatic capture(output logic [63:0] sd, output logic [63:0] lr,
                         output int rises, output int first_rise,
                         output int pulses, output int last_pulse);
    logic prev;
    prev = bus.Bclk;
    sd = '0; lr = '0; rises = 0; first_rise = -1; pulses = 0; last_pulse = -1;
    for (int i = 1; i <= 256; i++) begin
      step(1);
      if (bus.Bclk && !prev && rises < 64) begin
        sd[63-rises] = bus.Sdata;
        lr[63-rises] = bus.Lrclk;
        if (first_rise < 0) first_rise = i;
        rises++;
      end
      if (bus.SampleTaken) begin
        pulses++;
        last_pulse = i;
      end
      prev = bus.Bclk;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Enable = 1'b1;
    set_word(24'hA5C3F1, 24'hA5C3F1);
    step(3);
    n_cmp++;
    if ({bus.Bclk, bus.Lrclk, bus.Sdata, bus.SampleTaken, bus.Busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.Bclk, bus.Lrclk, bus.Sdata, bus.SampleTaken, bus.Busy});
    end
    rst = 1'b0;
    step(1);
    n_cmp++;
    if ({bus.SampleTaken, bus.Sdata, bus.Busy, bus.Lrclk, bus.Bclk} !== 5'b11100) begin
      n_bad++;
      $display("FAIL start_latch: got %b want 11100",
               {bus.SampleTaken, bus.Sdata, bus.Busy, bus.Lrclk, bus.Bclk});
    end
  endtask

  task automatic test_frame();
    logic [63:0] sd, lr;
    int rises, fr, pulses, lp;
    capture(sd, lr, rises, fr, pulses, lp);
    n_cmp++;
    if (sd !== {24'hA5C3F1, 8'h00, 24'hA5C3F1, 8'h00}) begin
      n_bad++; $display("FAIL mono_frame: got %h want %h", sd, {24'hA5C3F1, 8'h00, 24'hA5C3F1, 8'h00});
    end
    n_cmp++;
    if (lr !== LR_EXP) begin
      n_bad++; $display("FAIL lrclk_pattern: got %h want %h", lr, LR_EXP);
    end
    n_cmp++;
    if (rises !== 64 || fr !== 2) begin
      n_bad++; $display("FAIL bclk_timing: got rises=%0d first=%0d want 64/2", rises, fr);
    end
    n_cmp++;
    if (pulses !== 1 || lp !== 256) begin
      n_bad++; $display("FAIL sample_period: got pulses=%0d at=%0d want 1/256", pulses, lp);
    end
  endtask

  task automatic test_mid_change();
    logic [63:0] sd, lr;
    int rises, fr, pulses, lp;
    step(20);  // well inside the left slot
    set_word(24'h123456, 24'h123456);
    for (int i = 21; i <= 256; i++) step(1);
    // The capture edge at cycle 256 took 123456; the frame just ended was A5C3F1
    // (checked above), so now confirm the new word lands in the following frame.
    n_cmp++;
    if (bus.SampleTaken !== 1'b1) begin
      n_bad++; $display("FAIL mid_change_latch: got %b want 1", bus.SampleTaken);
    end
    capture(sd, lr, rises, fr, pulses, lp);
    n_cmp++;
    if (sd !== {24'h123456, 8'h00, 24'h123456, 8'h00}) begin
      n_bad++; $display("FAIL new_word_frame: got %h want %h", sd, {24'h123456, 8'h00, 24'h123456, 8'h00});
    end
  endtask

  task automatic test_hold_word();
    logic [63:0] sd, lr;
    int rises, fr, pulses, lp;
    // Change the input right after capture: the whole frame keeps the old word.
    set_word(24'hA5C3F1, 24'hA5C3F1);
    capture(sd, lr, rises, fr, pulses, lp);
    n_cmp++;
    if (sd !== {24'h123456, 8'h00, 24'h123456, 8'h00}) begin
      n_bad++; $display("FAIL held_word_frame: got %h want %h", sd, {24'h123456, 8'h00, 24'h123456, 8'h00});
    end
  endtask

  task automatic test_enable_stop();
    step(42);  // around bit 10
    bus.Enable = 1'b0;
    step(213);  // cycle 255: last bit still going out
    n_cmp++;
    if ({bus.Busy, bus.Bclk} !== 2'b11) begin
      n_bad++; $display("FAIL stop_frame_runs: got %b want 11", {bus.Busy, bus.Bclk});
    end
    step(1);
    n_cmp++;
    if ({bus.Busy, bus.Bclk, bus.Lrclk, bus.Sdata, bus.SampleTaken} !== 5'b0) begin
      n_bad++; $display("FAIL stop_idle: got %b want 00000",
                        {bus.Busy, bus.Bclk, bus.Lrclk, bus.Sdata, bus.SampleTaken});
    end
    step(10);
    n_cmp++;
    if ({bus.Busy, bus.Bclk} !== 2'b00) begin
      n_bad++; $display("FAIL stay_idle: got %b want 00", {bus.Busy, bus.Bclk});
    end
  endtask

  task automatic test_enable_toggle();
    bus.Enable = 1'b1;
    step(1);
    n_cmp++;
    if ({bus.SampleTaken, bus.Busy} !== 2'b11) begin
      n_bad++; $display("FAIL restart: got %b want 11", {bus.SampleTaken, bus.Busy});
    end
    step(40);
    bus.Enable = 1'b0;
    step(40);
    bus.Enable = 1'b1;
    step(176);
    n_cmp++;
    if ({bus.SampleTaken, bus.Busy} !== 2'b11) begin
      n_bad++; $display("FAIL no_gap: got %b want 11", {bus.SampleTaken, bus.Busy});
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] sd, lr;
    int rises, fr, pulses, lp;
    step(160);  // bit 40, right slot
    n_cmp++;
    if ({bus.Busy, bus.Lrclk} !== 2'b11) begin
      n_bad++; $display("FAIL pre_reset: got %b want 11", {bus.Busy, bus.Lrclk});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.Bclk, bus.Lrclk, bus.Sdata, bus.SampleTaken, bus.Busy} !== 5'b0) begin
      n_bad++; $display("FAIL async_reset: got %b want 00000",
                        {bus.Bclk, bus.Lrclk, bus.Sdata, bus.SampleTaken, bus.Busy});
    end
    set_word(24'hA5C3F1, RIGHT_FINAL);
    step(2);
    rst = 1'b0;
    step(1);
    n_cmp++;
    if ({bus.SampleTaken, bus.Sdata, bus.Busy} !== 3'b111) begin
      n_bad++; $display("FAIL post_reset_start: got %b want 111",
                        {bus.SampleTaken, bus.Sdata, bus.Busy});
    end
    capture(sd, lr, rises, fr, pulses, lp);
    n_cmp++;
    if (sd !== {24'hA5C3F1, 8'h00, RIGHT_FINAL, 8'h00} || lr !== LR_EXP) begin
      n_bad++; $display("FAIL fresh_frame: got %h/%h want %h/%h", sd, lr,
                        {24'hA5C3F1, 8'h00, RIGHT_FINAL, 8'h00}, LR_EXP);
    end
  endtask

  initial begin
    bus.Enable = 1'b0;
    bus.WaveIn = '0;
`ifdef I2S_STEREO_EN
    bus.WaveInR = '0;
`endif
    test_reset();
    test_frame();
    test_mid_change();
    test_hold_word();
    test_enable_stop();
    test_enable_toggle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
